// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and iteration count.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_e;

  localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/i_adder.sv
// 32-bit carry-lookahead adder/subtractor (4-bit lookahead groups).
// add_sub=1 inverts b, so a - b is formed with carry_in=1; C=1 then means no borrow.
module i_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_add_sub,
  input  logic             i_carry_in,
  output logic [WIDTH-1:0] o_sum_dif,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign b_eff = i_add_sub ? ~i_b : i_b;
  assign g     = i_a & b_eff;
  assign p     = i_a ^ b_eff;

  always_comb begin
    logic cg;
    logic gg;
    logic gp;
    c  = '0;
    cg = i_carry_in;
    for (int unsigned grp = 0; grp < WIDTH / 4; grp++) begin
      int unsigned b;
      b = grp * 4;
      c[b]   = cg;
      c[b+1] = g[b] | (p[b] & cg);
      c[b+2] = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & cg);
      c[b+3] = g[b+2] | (p[b+2] & g[b+1]) | (p[b+2] & p[b+1] & g[b])
             | (p[b+2] & p[b+1] & p[b] & cg);
      gg = g[b+3] | (p[b+3] & g[b+2]) | (p[b+3] & p[b+2] & g[b+1])
         | (p[b+3] & p[b+2] & p[b+1] & g[b]);
      gp = &p[b +: 4];
      cg = gg | (gp & cg);
    end
    c[WIDTH] = cg;
  end

  assign o_sum_dif = p ^ c[WIDTH-1:0];
  assign o_c       = c[WIDTH];
  assign o_v       = c[WIDTH] ^ c[WIDTH-1];

endmodule

// File: rtl/i_divider.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle via i_adder.
// Define DIV_SIGNED_EN to build signed (two's complement) support.
module i_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] shifted_r, sum_dif, r_nxt, q_nxt, q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             add_c, adder_v_unused, take;

  // Shift {R, Q} left; Q initially holds the dividend and fills with quotient bits.
  assign shifted_r = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

  i_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a        (shifted_r),
    .i_b        (dvs_q),
    .i_add_sub  (1'b1),
    .i_carry_in (1'b1),
    .o_sum_dif  (sum_dif),
    .o_c        (add_c),
    .o_v        (adder_v_unused)
  );

  assign take  = r_q[WIDTH-1] | add_c;
  assign r_nxt = take ? sum_dif : shifted_r;
  assign q_nxt = {q_q[WIDTH-2:0], take};

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d, rneg_q, rneg_d;
  logic dvd_neg, dvs_neg;
  assign dvd_neg = i_signed & i_dividend[WIDTH-1];
  assign dvs_neg = i_signed & i_divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
  assign dvs_mag = dvs_neg ? (~i_divisor + 1'b1) : i_divisor;
  assign q_fin   = qneg_q ? (~q_nxt + 1'b1) : q_nxt;
  assign r_fin   = rneg_q ? (~r_nxt + 1'b1) : r_nxt;
`else
  logic signed_unused;
  assign signed_unused = i_signed;
  assign dvd_mag = i_dividend;
  assign dvs_mag = i_divisor;
  assign q_fin   = q_nxt;
  assign r_fin   = r_nxt;
`endif

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_divisor == '0) begin
            quot_d  = '1;
            rem_d   = i_dividend;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = '0;
            q_d     = dvd_mag;
            dvs_d   = dvs_mag;
            cnt_d   = '0;
            dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
`endif
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = r_nxt;
        q_d   = q_nxt;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_ITERS - 1)) begin
          quot_d  = q_fin;
          rem_d   = r_fin;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_quotient  = quot_q;
  assign o_remainder = rem_q;
  assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_i_divider.sv
// Directed self-checking bench for i_divider (expectations follow DIV_SIGNED_EN).
module tb_i_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn = 1'b0;
  logic [31:0] dvd = '0;
  logic [31:0] dvs = '0;
  logic        ready, valid, dz;
  logic [31:0] quot, rem;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  i_divider #(.WIDTH(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_signed    (sgn),
    .i_dividend  (dvd),
    .i_divisor   (dvs),
    .o_ready     (ready),
    .o_valid     (valid),
    .o_quotient  (quot),
    .o_remainder (rem),
    .o_div_zero  (dz)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  // Issue one request at a negedge, then count cycles to o_valid.
  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic edz, input int lat,
                         input logic disturb);
    int n;
    int guard;
    guard = 0;
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_before"}, 32'(ready), 32'd1);
    sgn = s; dvd = a; dvs = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dvd = 32'h1234; dvs = 32'd3;
    n = 1;
    if (lat > 1) check({tag, " busy"}, 32'(ready), 32'd0);
    while (!valid && n < 100) begin
      if (disturb && (n == 5 || n == 20)) begin
        start = 1'b1; dvd = 32'd999; dvs = 32'd10;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " quotient"}, quot, eq);
    check({tag, " remainder"}, rem, er);
    check({tag, " div_zero"}, 32'(dz), 32'(edz));
    @(negedge clk);
    check({tag, " valid_pulse"}, 32'(valid), 32'd0);
    check({tag, " ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int vcount;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst valid", 32'(valid), 32'd0);
    check("rst quotient", quot, 32'd0);
    check("rst remainder", rem, 32'd0);
    check("rst div_zero", 32'(dz), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
    run_div("uFFFF/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0);
    run_div("uFFFF/8000", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 33, 1'b0);
`ifdef DIV_SIGNED_EN
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0);
    run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0);
`else
    run_div("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 33, 1'b0);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 33, 1'b0);
    run_div("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33, 1'b0);
`endif
    run_div("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b0);
    run_div("s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b0);
    run_div("ignore_start", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);

    // Asynchronous reset in the middle of CALC.
    sgn = 1'b0; dvd = 32'd100; dvs = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst ready", 32'(ready), 32'd1);
    check("midrst valid", 32'(valid), 32'd0);
    check("midrst quotient", quot, 32'd0);
    check("midrst remainder", rem, 32'd0);
    check("midrst div_zero", 32'(dz), 32'd0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      if (valid) vcount++;
    end
    check("midrst no_valid", 32'(vcount), 32'd0);
    run_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
